// File: rtl/debug_bus_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : debug_bus_serializer_pkg
//  Brief   : Shared FSM state encodings and derived-constant helpers for the
//            memory debug bus serializer.
//  Rev     : 1.0  initial release
// ============================================================================
package debug_bus_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_CHECKSUM = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    // Index width that stays legal when only one position exists.
    function automatic int idx_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

    function automatic int bytes_per_slot(input int slot_size, input int byte_size);
        return slot_size / byte_size;
    endfunction

    function automatic int total_bytes(input int addr_size, input int slot_size,
                                       input int byte_size);
        return (2 ** addr_size) * (slot_size / byte_size);
    endfunction

endpackage
`default_nettype wire

// File: rtl/debug_bus_serializer_byte_index_counter.sv
`default_nettype none
// ============================================================================
//  Module  : byte_index_counter
//  Brief   : Slot/byte index pair for the debug bus serializer. The byte index
//            wraps at BYTES_PER_SLOT and carries into the slot index; the slot
//            index spans a power-of-two slot count and wraps naturally.
//  Rev     : 1.0  initial release
// ============================================================================
module byte_index_counter #(
    parameter int SLOT_IDX_W     = 5,
    parameter int BYTE_IDX_W     = 2,
    parameter int BYTES_PER_SLOT = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_clear,
    input  logic                  i_enable,
    output logic [SLOT_IDX_W-1:0] o_slot_idx,
    output logic [BYTE_IDX_W-1:0] o_byte_idx,
    output logic                  o_last
);

    localparam logic [BYTE_IDX_W-1:0] c_LAST_BYTE = BYTE_IDX_W'(BYTES_PER_SLOT - 1);

    logic [SLOT_IDX_W-1:0] r_slot;
    logic [BYTE_IDX_W-1:0] r_byte;
    logic                  w_last_byte;
    logic                  w_last_slot;

    assign w_last_byte = (r_byte == c_LAST_BYTE);
    assign w_last_slot = &r_slot;

    // Advance byte index per enable; carry into the slot index on byte wrap.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_slot <= '0;
            r_byte <= '0;
        end else if (i_enable) begin
            if (w_last_byte) begin
                r_byte <= '0;
                r_slot <= r_slot + 1'b1;
            end else begin
                r_byte <= r_byte + 1'b1;
            end
        end
    end

    assign o_slot_idx = r_slot;
    assign o_byte_idx = r_byte;
    assign o_last     = w_last_slot && w_last_byte;

endmodule
`default_nettype wire

// File: rtl/debug_bus_serializer.sv
`default_nettype none
// ============================================================================
//  Module  : debug_bus_serializer
//  Brief   : Snapshots the flattened memory debug bus on request and streams
//            it out slot 0..N-1, MSB byte first, over a valid/ready handshake.
//            Optional macro DEBUG_SERIALIZER_CHECKSUM_EN appends a running XOR
//            of all data bytes as one final byte.
//  Rev     : 1.0  initial release
// ============================================================================
module debug_bus_serializer
    import debug_bus_serializer_pkg::*;
#(
    parameter int ADDR_SIZE = 5,
    parameter int SLOT_SIZE = 32,
    parameter int BYTE_SIZE = 8
) (
    input  logic                                  i_clk,
    input  logic                                  i_reset,
    input  logic                                  i_start,
    input  logic [(2**ADDR_SIZE)*SLOT_SIZE-1:0]   i_bus_debug,
    output logic [BYTE_SIZE-1:0]                  o_data,
    output logic                                  o_valid,
    input  logic                                  i_ready,
    output logic                                  o_busy,
    output logic                                  o_done
);

    localparam int c_N_SLOTS        = 2 ** ADDR_SIZE;
    localparam int c_BUS_W          = c_N_SLOTS * SLOT_SIZE;
    localparam int c_BYTES_PER_SLOT = bytes_per_slot(SLOT_SIZE, BYTE_SIZE);
    localparam int c_BYTE_IDX_W     = idx_width(c_BYTES_PER_SLOT);
    localparam int c_OFS_W          = idx_width(c_BUS_W);

    state_t                  r_state;
    state_t                  w_next;
    logic [c_BUS_W-1:0]      r_snapshot;
    logic [ADDR_SIZE-1:0]    w_slot_idx;
    logic [c_BYTE_IDX_W-1:0] w_byte_idx;
    logic                    w_last_all;
    logic [c_OFS_W-1:0]      w_bit_hi;
    logic [BYTE_SIZE-1:0]    w_snap_byte;
    logic                    w_cnt_en;
    logic                    w_cnt_clr;
    logic                    w_valid;
    logic                    w_busy;
    logic                    w_done;
    logic [BYTE_SIZE-1:0]    w_data;
`ifdef DEBUG_SERIALIZER_CHECKSUM_EN
    logic [BYTE_SIZE-1:0]    r_xor;
`endif

    byte_index_counter #(
        .SLOT_IDX_W     (ADDR_SIZE),
        .BYTE_IDX_W     (c_BYTE_IDX_W),
        .BYTES_PER_SLOT (c_BYTES_PER_SLOT)
    ) u_index (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clear    (w_cnt_clr),
        .i_enable   (w_cnt_en),
        .o_slot_idx (w_slot_idx),
        .o_byte_idx (w_byte_idx),
        .o_last     (w_last_all)
    );

    // Locate the current byte: slot base plus the top bit of the byte, counted from the slot MSB down.
    always_comb begin
        w_bit_hi = c_OFS_W'(w_slot_idx) * c_OFS_W'(SLOT_SIZE)
                 + c_OFS_W'(SLOT_SIZE - 1)
                 - c_OFS_W'(w_byte_idx) * c_OFS_W'(BYTE_SIZE);
    end

    assign w_snap_byte = r_snapshot[w_bit_hi -: BYTE_SIZE];

    // Capture the memory image once per dump so later writes cannot tear the stream.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_snapshot <= '0;
        end else if (w_cnt_clr) begin
            r_snapshot <= i_bus_debug;
        end
    end

`ifdef DEBUG_SERIALIZER_CHECKSUM_EN
    // Running XOR of every accepted data byte, restarted with each dump.
    always_ff @(posedge i_clk) begin
        if (i_reset || w_cnt_clr) begin
            r_xor <= '0;
        end else if (w_cnt_en) begin
            r_xor <= r_xor ^ w_snap_byte;
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and Moore outputs; data is forced to zero whenever nothing is offered.
    always_comb begin
        w_next    = r_state;
        w_valid   = 1'b0;
        w_busy    = 1'b1;
        w_done    = 1'b0;
        w_data    = '0;
        w_cnt_en  = 1'b0;
        w_cnt_clr = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (i_start) begin
                    w_cnt_clr = 1'b1;
                    w_next    = ST_SEND;
                end
            end
            ST_SEND: begin
                w_valid = 1'b1;
                w_data  = w_snap_byte;
                if (i_ready) begin
                    w_cnt_en = 1'b1;
                    if (w_last_all) begin
`ifdef DEBUG_SERIALIZER_CHECKSUM_EN
                        w_next = ST_CHECKSUM;
`else
                        w_next = ST_DONE;
`endif
                    end
                end
            end
`ifdef DEBUG_SERIALIZER_CHECKSUM_EN
            ST_CHECKSUM: begin
                w_valid = 1'b1;
                w_data  = r_xor;
                if (i_ready) begin
                    w_next = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_busy = 1'b0;
                w_next = ST_IDLE;
            end
        endcase
    end

    assign o_data  = w_data;
    assign o_valid = w_valid;
    assign o_busy  = w_busy;
    assign o_done  = w_done;

endmodule
`default_nettype wire
